clk_div_ctrl: RTL and testbench

Programmable front-end for the microcontroller clock divider; sits directly upstream of it and drives its divide-ratio and enable inputs. Accepts divisor writes from the CPU register interface and applies them with a safe-switch sequence: freeze divider, drain, load new ratio, resume. Rejects illegal writes and reports status to software.

---
 rtl/clk_div_ctrl.sv | 136 +++++++++++++
 tb/tb_clk_div_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
//
// Programmable front-end for the microcontroller clock divider. It sits
// directly upstream of the divider and drives its divide-ratio and enable
// inputs. A CPU write of a new divisor is applied with a safe-switch sequence:
// freeze the divider, wait long enough for any in-flight divided period to
// drain, load the new ratio, then resume. Illegal or colliding writes are
// rejected and reported through a sticky error flag.
//
// Ports:
//   i_clk      system clock
//   i_rst      synchronous reset, active-high
//   i_run      software run request for the divided clock
//   i_wr_en    one-cycle divisor write strobe
//   i_wr_div   divisor value written with i_wr_en
//   i_err_clr  clears the sticky error flag
//   o_div      divisor to the clock divider (never 0)
//   o_enable   enable to the clock divider
//   o_busy     switch sequence in progress
//   o_done     one-cycle pulse: write completed
//   o_err      sticky: illegal (zero) or dropped write
// -----------------------------------------------------------------------------
module clk_div_ctrl #(
  parameter int DIV_W         = 4,
  parameter int DEFAULT_DIV   = 1,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic             i_wr_en,
  input  logic [DIV_W-1:0] i_wr_div,
  input  logic             i_err_clr,
  output logic [DIV_W-1:0] o_div,
  output logic             o_enable,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    LOAD   = 2'd2,
    RESUME = 2'd3
  } state_t;

  localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_reg;
  logic [DIV_W-1:0] pending_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic wr_zero;
  logic wr_legal_new;
  logic err_set;

  assign wr_zero      = i_wr_en && (i_wr_div == '0);
  assign wr_legal_new = i_wr_en && (i_wr_div != '0) && (i_wr_div != o_div);

  // Any write outside IDLE collides with a running switch and is dropped;
  // a zero divisor is never legal.
  assign err_set = (state_reg == IDLE) ? wr_zero : i_wr_en;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      pending_reg <= DIV_RESET;
      cnt_reg     <= '0;
      o_div       <= DIV_RESET;
      o_enable    <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      // o_done is a pulse: only the completion paths below raise it.
      o_done <= 1'b0;

      // Setting wins over a simultaneous clear so no error is ever lost.
      if (err_set) begin
        o_err <= 1'b1;
      end else if (i_err_clr) begin
        o_err <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          o_enable <= i_run;
          o_busy   <= 1'b0;
          if (wr_legal_new) begin
            pending_reg <= i_wr_div;
            cnt_reg     <= '0;
            o_enable    <= 1'b0;
            o_busy      <= 1'b1;
            state_reg   <= DRAIN;
          end else if (i_wr_en && !wr_zero) begin
            // Rewriting the current ratio needs no switch; just acknowledge.
            o_done <= 1'b1;
          end
        end

        DRAIN: begin
          // Divider stays frozen for SETTLE_CYCLES cycles so the longest
          // divided period can complete before the ratio changes.
          o_enable <= 1'b0;
          cnt_reg  <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            state_reg <= LOAD;
          end
        end

        LOAD: begin
          o_div     <= pending_reg;
          o_enable  <= 1'b0;
          state_reg <= RESUME;
        end

        RESUME: begin
          // i_run is only looked at again here, after the new ratio is in.
          o_busy    <= 1'b0;
          o_done    <= 1'b1;
          o_enable  <= i_run;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
`timescale 1ns/1ps
module tb_clk_div_ctrl;

  localparam int DIV_W = 4;
  localparam int S     = 16;

  logic             clk;
  logic             rst;
  logic             run;
  logic             wr_en;
  logic [DIV_W-1:0] wr_div;
  logic             err_clr;
  logic [DIV_W-1:0] div;
  logic             enable;
  logic             busy;
  logic             done;
  logic             err;

  int n_cmp  = 0;
  int n_fail = 0;

  clk_div_ctrl #(
    .DIV_W(DIV_W),
    .DEFAULT_DIV(1),
    .SETTLE_CYCLES(S),
    .CNT_W(5)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_run(run),
    .i_wr_en(wr_en),
    .i_wr_div(wr_div),
    .i_err_clr(err_clr),
    .o_div(div),
    .o_enable(enable),
    .o_busy(busy),
    .o_done(done),
    .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one active edge and settle, so outputs are sampled away
  // from the edge and inputs can be changed for the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a write and let the full switch sequence run out (no checking).
  task automatic setup_write(input logic [DIV_W-1:0] v);
    wr_en  = 1'b1;
    wr_div = v;
    tick();
    wr_en  = 1'b0;
    for (int i = 0; i < S + 4; i++) tick();
  endtask

  task automatic test_reset();
    run = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({div, enable, busy, done, err} !== {4'd1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL reset_state: got div=%0d en=%b busy=%b done=%b err=%b, want div=1 en=0 busy=0 done=0 err=0",
               div, enable, busy, done, err);
      n_fail++;
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({div, enable, busy, done, err} !== {4'd1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL reset_release: got div=%0d en=%b busy=%b done=%b err=%b, want div=1 en=1 busy=0 done=0 err=0",
               div, enable, busy, done, err);
      n_fail++;
    end
    $display("test_reset: div=%0d en=%b", div, enable);
  endtask

  task automatic test_switch();
    // Write 6 at edge T; after each tick we are at "T+k+1".
    wr_en  = 1'b1;
    wr_div = 4'd6;
    tick();
    wr_en  = 1'b0;
    n_cmp++;
    if ({div, enable, busy, done} !== {4'd1, 1'b0, 1'b1, 1'b0}) begin
      $display("FAIL switch_start: got div=%0d en=%b busy=%b done=%b, want 1/0/1/0", div, enable, busy, done);
      n_fail++;
    end
    for (int k = 1; k <= S; k++) begin
      tick();
      n_cmp++;
      if ({div, enable, busy, done} !== {4'd1, 1'b0, 1'b1, 1'b0}) begin
        $display("FAIL switch_drain[%0d]: got div=%0d en=%b busy=%b done=%b, want 1/0/1/0", k, div, enable, busy, done);
        n_fail++;
      end
    end
    tick();
    n_cmp++;
    if ({div, enable, busy, done} !== {4'd6, 1'b0, 1'b1, 1'b0}) begin
      $display("FAIL switch_load: got div=%0d en=%b busy=%b done=%b, want 6/0/1/0", div, enable, busy, done);
      n_fail++;
    end
    tick();
    n_cmp++;
    if ({div, enable, busy, done} !== {4'd6, 1'b1, 1'b0, 1'b1}) begin
      $display("FAIL switch_done: got div=%0d en=%b busy=%b done=%b, want 6/1/0/1", div, enable, busy, done);
      n_fail++;
    end
    tick();
    n_cmp++;
    if ({div, enable, busy, done} !== {4'd6, 1'b1, 1'b0, 1'b0}) begin
      $display("FAIL switch_after: got div=%0d en=%b busy=%b done=%b, want 6/1/0/0", div, enable, busy, done);
      n_fail++;
    end
    $display("test_switch: write 6 -> div=%0d en=%b", div, enable);
  endtask

  task automatic test_illegal();
    wr_en  = 1'b1;
    wr_div = 4'd0;
    tick();
    wr_en  = 1'b0;
    n_cmp++;
    if ({div, enable, busy, done, err} !== {4'd6, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      $display("FAIL illegal_zero: got div=%0d en=%b busy=%b done=%b err=%b, want 6/1/0/0/1", div, enable, busy, done, err);
      n_fail++;
    end
    tick();
    n_cmp++;
    if ({done, err} !== {1'b0, 1'b1}) begin
      $display("FAIL illegal_sticky: got done=%b err=%b, want done=0 err=1", done, err);
      n_fail++;
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_cmp++;
    if (err !== 1'b0) begin
      $display("FAIL err_clear: got err=%b, want 0", err);
      n_fail++;
    end
    err_clr = 1'b1;
    wr_en   = 1'b1;
    wr_div  = 4'd0;
    tick();
    err_clr = 1'b0;
    wr_en   = 1'b0;
    n_cmp++;
    if (err !== 1'b1) begin
      $display("FAIL err_set_wins: got err=%b, want 1", err);
      n_fail++;
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_cmp++;
    if (err !== 1'b0) begin
      $display("FAIL err_clear2: got err=%b, want 0", err);
      n_fail++;
    end
    $display("test_illegal: div=%0d err=%b", div, err);
  endtask

  task automatic test_same();
    wr_en  = 1'b1;
    wr_div = 4'd6;
    tick();
    wr_en  = 1'b0;
    n_cmp++;
    if ({div, enable, busy, done, err} !== {4'd6, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      $display("FAIL same_done: got div=%0d en=%b busy=%b done=%b err=%b, want 6/1/0/1/0", div, enable, busy, done, err);
      n_fail++;
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if ({div, enable, busy, done} !== {4'd6, 1'b1, 1'b0, 1'b0}) begin
        $display("FAIL same_after[%0d]: got div=%0d en=%b busy=%b done=%b, want 6/1/0/0", k, div, enable, busy, done);
        n_fail++;
      end
    end
    $display("test_same: write 6 again -> done pulse only");
  endtask

  task automatic test_back_to_back();
    int done_cnt = 0;
    int bad_div  = 0;
    wr_en  = 1'b1;
    wr_div = 4'd3;
    tick();                       // edge T
    wr_en  = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    wr_en  = 1'b1;                // collides at edge T+4
    wr_div = 4'd5;
    run    = 1'b0;                // dropped mid-DRAIN
    tick();
    wr_en  = 1'b0;
    n_cmp++;
    if ({busy, err, enable} !== {1'b1, 1'b1, 1'b0}) begin
      $display("FAIL drop_err: got busy=%b err=%b en=%b, want busy=1 err=1 en=0", busy, err, enable);
      n_fail++;
    end
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done === 1'b1) done_cnt++;
      if (div === 4'd5 || div === 4'd0) bad_div++;
    end
    n_cmp++;
    if ({div, enable, busy} !== {4'd3, 1'b0, 1'b0}) begin
      $display("FAIL drop_final: got div=%0d en=%b busy=%b, want div=3 en=0 busy=0", div, enable, busy);
      n_fail++;
    end
    n_cmp++;
    if (done_cnt !== 1) begin
      $display("FAIL drop_done_count: got %0d done pulses, want 1", done_cnt);
      n_fail++;
    end
    n_cmp++;
    if (bad_div !== 0) begin
      $display("FAIL drop_div_value: got %0d cycles with div 5 or 0, want 0", bad_div);
      n_fail++;
    end
    run     = 1'b1;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    $display("test_back_to_back: write 3 then 5 -> div=%0d done_pulses=%0d", div, done_cnt);
  endtask

  task automatic test_reset_mid();
    int done_cnt = 0;
    setup_write(4'd4);
    n_cmp++;
    if ({div, enable, busy} !== {4'd4, 1'b1, 1'b0}) begin
      $display("FAIL midrst_setup: got div=%0d en=%b busy=%b, want 4/1/0", div, enable, busy);
      n_fail++;
    end
    wr_en  = 1'b1;
    wr_div = 4'd7;
    tick();                       // edge T
    wr_en  = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    rst = 1'b1;                   // sampled at edge T+10
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({div, enable, busy, done, err} !== {4'd1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL midrst_state: got div=%0d en=%b busy=%b done=%b err=%b, want 1/0/0/0/0", div, enable, busy, done, err);
      n_fail++;
    end
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done === 1'b1) done_cnt++;
    end
    n_cmp++;
    if ({done_cnt, div, enable, busy} !== {32'd0, 4'd1, 1'b1, 1'b0}) begin
      $display("FAIL midrst_abort: got done_pulses=%0d div=%0d en=%b busy=%b, want 0/1/1/0", done_cnt, div, enable, busy);
      n_fail++;
    end
    wr_en  = 1'b1;
    wr_div = 4'd2;
    tick();
    wr_en  = 1'b0;
    for (int k = 0; k < S + 1; k++) tick();
    tick();
    n_cmp++;
    if ({div, enable, busy, done} !== {4'd2, 1'b1, 1'b0, 1'b1}) begin
      $display("FAIL midrst_rewrite: got div=%0d en=%b busy=%b done=%b, want 2/1/0/1", div, enable, busy, done);
      n_fail++;
    end
    $display("test_reset_mid: after abort and rewrite div=%0d", div);
  endtask

  initial begin
    rst     = 1'b1;
    run     = 1'b0;
    wr_en   = 1'b0;
    wr_div  = '0;
    err_clr = 1'b0;
    test_reset();
    test_switch();
    test_illegal();
    test_same();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
